// File: rtl/gf180mcu_fd_sc_mcu7t5v0__segdrv_seq.sv
// Segmented driver enable sequencer.
// Ramps thermometer leg enables one leg per STEP cycles.
module gf180mcu_fd_sc_mcu7t5v0__segdrv_seq #(
  parameter int NSEG = 4,
  parameter int STEP = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            I,
  output logic            Z,
  output logic [NSEG-1:0] SEGEN,
  output logic            BUSY,
  inout  wire             VDD,
  inout  wire             VSS
);

  localparam int CW = $clog2(NSEG + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NSEG);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [3:0]    SC_LAST = 4'(STEP - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_RAMP_UP,
    S_ON,
    S_RAMP_DN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sc_q, sc_d;
  logic          z_q, z_d;
  logic          busy_q, busy_d;

  // Supply pins carry no logic function.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  // Next-state, leg count and step counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    unique case (state_q)
      S_OFF: begin
        if (EN) begin
          cnt_d   = CNT_ONE;
          sc_d    = '0;
          state_d = (NSEG == 1) ? S_ON : S_RAMP_UP;
        end
      end
      S_RAMP_UP: begin
        if (!EN) begin
          cnt_d   = cnt_q - CNT_ONE;
          sc_d    = '0;
          state_d = (cnt_q == CNT_ONE) ? S_OFF : S_RAMP_DN;
        end else if (sc_q == SC_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
          sc_d  = '0;
          if (cnt_q + CNT_ONE == CNT_MAX)
            state_d = S_ON;
        end else begin
          sc_d = sc_q + 4'd1;
        end
      end
      S_ON: begin
        if (!EN) begin
          cnt_d   = CNT_MAX - CNT_ONE;
          sc_d    = '0;
          state_d = (NSEG == 1) ? S_OFF : S_RAMP_DN;
        end
      end
      S_RAMP_DN: begin
        if (EN) begin
          cnt_d   = cnt_q + CNT_ONE;
          sc_d    = '0;
          state_d = (cnt_q + CNT_ONE == CNT_MAX)
                    ? S_ON : S_RAMP_UP;
        end else if (sc_q == SC_LAST) begin
          cnt_d   = cnt_q - CNT_ONE;
          sc_d    = '0;
          if (cnt_q == CNT_ONE)
            state_d = S_OFF;
        end else begin
          sc_d = sc_q + 4'd1;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
        sc_d    = '0;
      end
    endcase
  end

  // Busy flag and data level; data freezes when bank goes dark.
  always_comb begin
    busy_d = (state_d == S_RAMP_UP) ||
             (state_d == S_RAMP_DN);
    z_d    = (cnt_d != '0) ? I : z_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      sc_q    <= '0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
    end
  end

  // Thermometer decode of the registered leg count.
  always_comb begin
    SEGEN = '0;
    for (int k = 0; k < NSEG; k++)
      SEGEN[k] = (cnt_q > CW'(k));
  end

  assign Z    = z_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__segdrv_seq.sv
// Bench for the segmented driver sequencer.
// Directed vector table plus randomized run against a model.
module tb_gf180mcu_fd_sc_mcu7t5v0__segdrv_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic din = 1'b0;
  wire  vdd = 1'b1;
  wire  vss = 1'b0;

  logic       z4, z1, z3;
  logic       b4, b1, b3;
  logic [3:0] s4;
  logic [0:0] s1;
  logic [2:0] s3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__segdrv_seq #(.NSEG(4), .STEP(2)) dut4 (
    .CLK(clk), .RST(rst), .EN(en), .I(din),
    .Z(z4), .SEGEN(s4), .BUSY(b4), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__segdrv_seq #(.NSEG(1), .STEP(1)) dut1 (
    .CLK(clk), .RST(rst), .EN(en), .I(din),
    .Z(z1), .SEGEN(s1), .BUSY(b1), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__segdrv_seq #(.NSEG(3), .STEP(3)) dut3 (
    .CLK(clk), .RST(rst), .EN(en), .I(din),
    .Z(z3), .SEGEN(s3), .BUSY(b3), .VDD(vdd), .VSS(vss)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       i;
    logic [3:0] seg;
    logic       busy;
    logic       z;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic d,
                     input int seg, input logic b, input logic z);
    vec_t v;
    v.rst = r; v.en = e; v.i = d;
    v.seg = 4'(seg); v.busy = b; v.z = z;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic d);
    @(negedge clk);
    rst = r; en = e; din = d;
    @(posedge clk);
    #1;
  endtask

  // Reference model: leg count walks toward the target level,
  // first move or reversal is immediate, else one leg per STEP.
  int   ns[3] = '{4, 1, 3};
  int   st[3] = '{2, 1, 3};
  int   mcnt[3];
  int   msince[3];
  int   mdir[3];
  bit   mmov[3];
  logic mz[3];

  task automatic mstep(input int k, input logic r,
                       input logic e, input logic d);
    int tgt;
    int dir;
    if (r) begin
      mcnt[k] = 0; msince[k] = 0; mdir[k] = 0;
      mmov[k] = 0; mz[k] = 1'b0;
      return;
    end
    tgt = e ? ns[k] : 0;
    if (mcnt[k] != tgt) begin
      dir = (tgt > mcnt[k]) ? 1 : -1;
      if (!mmov[k] || dir != mdir[k] || msince[k] >= st[k]) begin
        mcnt[k] += dir;
        msince[k] = 1;
      end else begin
        msince[k]++;
      end
      mdir[k] = dir;
    end
    mmov[k] = (mcnt[k] != tgt);
    if (mcnt[k] != 0) mz[k] = d;
  endtask

  function automatic int act_seg(input int k);
    case (k)
      0: return int'(s4);
      1: return int'(s1);
      default: return int'(s3);
    endcase
  endfunction

  function automatic int act_busy(input int k);
    case (k)
      0: return int'(b4);
      1: return int'(b1);
      default: return int'(b3);
    endcase
  endfunction

  function automatic int act_z(input int k);
    case (k)
      0: return int'(z4);
      1: return int'(z1);
      default: return int'(z3);
    endcase
  endfunction

  initial begin
    logic r;
    logic e;
    logic d;
    int   exp_busy;

    // Reset with EN and I high.
    add(1,1,1, 0,0,0);
    add(1,1,1, 0,0,0);
    // Ramp up.
    add(0,1,1, 1,1,1);
    add(0,1,1, 1,1,1);
    add(0,1,1, 3,1,1);
    add(0,1,1, 3,1,1);
    add(0,1,1, 7,1,1);
    add(0,1,1, 7,1,1);
    add(0,1,1, 15,0,1);
    add(0,1,1, 15,0,1);
    // Data path while fully on.
    add(0,1,1, 15,0,1);
    add(0,1,0, 15,0,0);
    add(0,1,0, 15,0,0);
    add(0,1,1, 15,0,1);
    // Ramp down with I toggling; Z freezes at zero legs.
    add(0,0,0, 7,1,0);
    add(0,0,1, 7,1,1);
    add(0,0,0, 3,1,0);
    add(0,0,1, 3,1,1);
    add(0,0,0, 1,1,0);
    add(0,0,1, 1,1,1);
    add(0,0,0, 0,0,1);
    add(0,0,1, 0,0,1);
    add(0,0,0, 0,0,1);
    // Reversal mid ramp-up.
    add(0,1,1, 1,1,1);
    add(0,1,1, 1,1,1);
    add(0,1,1, 3,1,1);
    add(0,0,1, 1,1,1);
    add(0,0,1, 1,1,1);
    add(0,0,0, 0,0,1);
    // Reset mid ramp.
    add(0,1,1, 1,1,1);
    add(0,1,1, 1,1,1);
    add(0,1,1, 3,1,1);
    add(0,1,1, 3,1,1);
    add(0,1,1, 7,1,1);
    add(1,1,1, 0,0,0);
    add(0,0,1, 0,0,0);
    // Release from reset enables leg 0 at once.
    add(1,1,1, 0,0,0);
    add(0,1,1, 1,1,1);
    add(0,0,0, 0,0,1);

    foreach (vq[n]) begin
      cyc(vq[n].rst, vq[n].en, vq[n].i);
      check($sformatf("vec%0d segen", n), int'(s4), int'(vq[n].seg));
      check($sformatf("vec%0d busy", n), int'(b4), int'(vq[n].busy));
      check($sformatf("vec%0d z", n), int'(z4), int'(vq[n].z));
    end

    // Single leg, unit step: no ramp, BUSY never set.
    cyc(1, 0, 0);
    check("n1 reset segen", int'(s1), 0);
    cyc(0, 1, 1);
    check("n1 on segen", int'(s1), 1);
    check("n1 on busy", int'(b1), 0);
    check("n1 on z", int'(z1), 1);
    for (int j = 0; j < 3; j++) begin
      cyc(0, 1, 1'(j & 1));
      check($sformatf("n1 hold%0d busy", j), int'(b1), 0);
      check($sformatf("n1 hold%0d z", j), int'(z1), j & 1);
    end
    cyc(0, 0, 1);
    check("n1 off segen", int'(s1), 0);
    check("n1 off busy", int'(b1), 0);
    check("n1 off z", int'(z1), 0);

    // Randomized run against the model on all three configs.
    e = 1'b0;
    for (int n = 0; n < 800; n++) begin
      r = (n == 0) || ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) e = ~e;
      d = 1'($urandom_range(0, 1));
      cyc(r, e, d);
      for (int k = 0; k < 3; k++) begin
        mstep(k, r, e, d);
        exp_busy = (mcnt[k] > 0 && mcnt[k] < ns[k]) ? 1 : 0;
        check($sformatf("rnd%0d cfg%0d segen", n, k),
              act_seg(k), (1 << mcnt[k]) - 1);
        check($sformatf("rnd%0d cfg%0d busy", n, k),
              act_busy(k), exp_busy);
        check($sformatf("rnd%0d cfg%0d z", n, k),
              act_z(k), int'(mz[k]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__segdrv_seq.md
# gf180mcu_fd_sc_mcu7t5v0__segdrv_seq

Segmented-driver enable sequencer that sits directly upstream of a bank of parallel high-drive inverter legs (inv_12 class) driving a high-fanout or off-block net. It provides a registered data level `Z` to all legs and a thermometer-coded set of per-leg enables `SEGEN`. Legs are switched on and off one at a time on a fixed cycle pitch, which limits di/dt on VDD/VSS at enable and disable.

## Interface
- `NSEG`, default 4: number of driver legs / enable bits; legal range 1..8.
- `STEP`, default 2: clock cycles between successive leg changes; legal range 1..15.

- `CLK`  input  1  rising-edge clock.
- `RST`  input  1  synchronous, active-high reset.
- `EN`  input  1  drive-enable request. 1 = ramp legs on; 0 = ramp legs off.
- `I`  input  1  data level to be driven.
- `Z`  output  1  registered data level presented to all legs.
- `SEGEN`  output  NSEG  thermometer leg enables. Bit 0 turns on first and off last.
- `BUSY`  output  1  high while a ramp is in progress.
- `VDD`  inout  1  supply.
- `VSS`  inout  1  ground.

## Operation
- State: a 2-bit FSM with states OFF, RAMP_UP, ON and RAMP_DN; a segment count `cnt` of width clog2(NSEG+1); and a 4-bit step counter `sc`.
- `SEGEN` = thermometer(`cnt`). `SEGEN` is driven straight from the `cnt` register; there is no combinational path from inputs to outputs.
- OFF (`cnt`=0):
  - EN=1: `cnt`←1 and `sc`←0.
  - Next state is ON if NSEG=1, otherwise RAMP_UP.
- RAMP_UP:
  - EN=0: reverse. `cnt`←`cnt`−1, `sc`←0, next state RAMP_DN, or OFF if the new `cnt` is 0.
  - EN=1 and `sc`=STEP−1: `cnt`←`cnt`+1, `sc`←0. Next state is ON when the new `cnt`=NSEG.
  - Otherwise: `sc`←`sc`+1.
- ON (`cnt`=NSEG): EN=0 gives `cnt`←NSEG−1 and `sc`←0. Next state is RAMP_DN, or OFF if NSEG=1.
- RAMP_DN mirrors RAMP_UP:
  - EN=1: reverse upward by one leg immediately.
  - `sc`=STEP−1: remove one leg. Next state is OFF when `cnt` reaches 0.
- `BUSY` = registered (next state ∈ {RAMP_UP, RAMP_DN}).
- `Z`: on each edge where the next `cnt`≠0, `Z`←`I`. When the next `cnt`=0, `Z` holds its value, so a disabled bank sees no data toggling.
- `cnt` never exceeds NSEG and never goes below 0. `sc` never exceeds STEP−1.
- Reset (RST sampled high, highest priority): state OFF, `cnt`=0, `sc`=0, `SEGEN`=0, `Z`=0, `BUSY`=0. This holds regardless of EN and I, including when RST is asserted mid-ramp.

## Timing
- EN is sampled at the rising edge of CLK.
- Ramp-up timing, with EN first sampled high at edge k from OFF:
  - `SEGEN` shows n legs after edge k+(n−1)·STEP.
  - Full on is reached after edge k+(NSEG−1)·STEP.
- Ramp-down timing is identical, counting down from ON.
- `BUSY` rises on the same edge as the first leg change and falls on the edge that reaches full on or zero.
- Reversal: the first leg change in the new direction occurs on the same edge EN is sampled changed. Subsequent changes follow every STEP cycles.
- `I`→`Z` latency is 1 cycle while any leg is enabled.
- Release from reset: the first edge with RST=0 and EN=1 enables leg 0.

## Test plan
1. Reset: RST=1 for 2 cycles with EN=1, I=1 → `SEGEN`=0000, `Z`=0, `BUSY`=0 after the first reset edge.
2. Ramp up (NSEG=4, STEP=2): EN=1 first sampled at edge 0 →
   - `SEGEN`=0001 @0, 0011 @2, 0111 @4, 1111 @6.
   - `BUSY`=1 after edges 0–5 and 0 after edge 6.
3. Ramp down: EN=0 sampled at edge 0 while ON, I toggling every cycle →
   - `SEGEN`=0111 @0, 0011 @2, 0001 @4, 0000 @6.
   - `Z` tracks I until edge 5, then stays frozen from edge 6 onward.
4. Reversal: EN=1 @0, `SEGEN`=0011 @2, EN=0 sampled @3 →
   - `SEGEN`=0001 @3, 0000 @5.
   - `BUSY`=0 @5 and the state is OFF.
5. Data path while ON: I = 1,0,0,1 on successive edges → `Z` = 1,0,0,1, each delayed exactly one cycle.
6. Corners:
   - RST asserted while `SEGEN`=0111 → 0000 on the next edge.
   - NSEG=1, STEP=1: EN rise → `SEGEN`=1 after one edge with `BUSY` never asserted. EN fall → `SEGEN`=0 after one edge.
